multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath (shared instr/data memory, IR, ALUOut, single ALU).
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives all datapath mux selects and
//  write strobes, evaluates BEQ/BNE/BLT/BLE, handles memory wait states with timeout, counts retired instrs.
//  Consumes the opcode from IR; ALU_op encoding is the datapath's 3-bit code (000 R,001 sub-cmp,010 BNE,
//  011 add,100 LUI,101 ORI,111 don't care).
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for mem_ready_i in a memory state before abort (1..255)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      asynchronous reset, active-high
//  instr_op_i     in   6      opcode from IR (stable after FETCH)
//  zero_i         in   1      ALU zero flag (current cycle)
//  neg_i          in   1      ALU result sign bit (current cycle)
//  mem_ready_i    in   1      memory completes access this cycle
//  pc_write_o     out  1      PC load strobe
//  ir_write_o     out  1      IR load strobe
//  i_or_d_o       out  1      mem addr: 0=PC, 1=ALUOut
//  mem_read_o     out  1      memory read request
//  mem_write_o    out  1      memory write request
//  reg_write_o    out  1      register file write strobe
//  reg_dst_o      out  2      00 rt, 01 rd, 10 $31
//  mem_to_reg_o   out  2      00 ALUOut, 01 MDR, 10 LUI result, 11 PC (link)
//  alu_src_a_o    out  1      0 PC, 1 rs
//  alu_src_b_o    out  2      00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
//  alu_op_o       out  3      ALU operation class (encoding above)
//  pc_src_o       out  2      00 ALU result, 01 ALUOut, 10 jump target
//  state_o        out  4      current state code (debug)
//  illegal_o      out  1      1-cycle pulse: unsupported opcode in DECODE
//  bus_err_o      out  1      1-cycle pulse: memory timeout
//  instr_count_o  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEM_ADDR=2 MEM_RD=3 MEM_WB=4 MEM_WR=5 EXEC=6 ALU_WB=7 BRANCH=8 JUMP=9
//   JAL=10 LUI_WB=11. Outputs Moore-decoded from state (+instr_op_i for EXEC/BRANCH alu_op).
//  Reset (async): state=FETCH, wait cnt=0, instr_count_o=0; while rst_i=1 all strobes
//   (pc_write,ir_write,mem_read,mem_write,reg_write,illegal,bus_err)=0, all selects=0, state_o=0.
//  FETCH: mem_read=1,i_or_d=0,src_a=0,src_b=01,alu_op=011; on mem_ready_i: ir_write=1,pc_write=1,
//   pc_src=00, ->DECODE; else stay. DECODE: src_a=0,src_b=11,alu_op=011 (branch target->ALUOut); 1 cycle.
//  DECODE next by opcode: 0->EXEC; 2->JUMP; 3->JAL; 4/5/6/7->BRANCH; 8/13->EXEC; 15->LUI_WB;
//   35/43->MEM_ADDR; other->FETCH with illegal_o=1, not counted.
//  MEM_ADDR: src_a=1,src_b=10,alu_op=011; ->MEM_RD (35) or MEM_WR (43).
//  MEM_RD: mem_read=1,i_or_d=1; wait for ready ->MEM_WB. MEM_WB: reg_write=1,reg_dst=00,mem_to_reg=01.
//  MEM_WR: mem_write=1,i_or_d=1; on ready ->FETCH (retire).
//  EXEC: src_a=1; op0: src_b=00,alu_op=000; op8: src_b=10,011; op13: src_b=10,101 ->ALU_WB.
//  ALU_WB: reg_write=1,mem_to_reg=00,reg_dst=01 if op0 else 00 ->FETCH.
//  LUI_WB: alu_op=100,reg_write=1,reg_dst=00,mem_to_reg=10 ->FETCH.
//  BRANCH: src_a=1,src_b=00,alu_op=001 (op4/6/7) or 010 (op5); taken = op4:zero_i, op5:!zero_i,
//   op6:neg_i, op7:neg_i|zero_i; pc_write=taken,pc_src=01 ->FETCH.
//  JUMP: pc_write=1,pc_src=10. JAL: same + reg_write=1,reg_dst=10,mem_to_reg=11. ->FETCH.
//  Retire: instr_count_o +1 on last cycle of MEM_WB, MEM_WR(ready), ALU_WB, LUI_WB, BRANCH, JUMP, JAL.
//  Wait cnt: counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready_i=0, cleared on state change;
//   reaching MEM_TIMEOUT with no ready: bus_err_o=1 one cycle, no strobe that cycle, ->FETCH
//   (FETCH timeout restarts FETCH at same PC); aborted instr not counted.
//  mem_ready_i on the same cycle the count hits MEM_TIMEOUT: ready wins, no error.
//  mem_read_o and mem_write_o never both 1; reg_write_o and mem_write_o never both 1.
//  Reset mid-instruction: strobes drop same cycle, restart FETCH after release, no partial writeback.
// TESTING
//  add (op0), ready immediate -> states 0,1,6,7; reg_write=1,reg_dst=01 in 7; count 0->1 in 4 cycles.
//  lw (op35), ready after 3 waits in MEM_RD -> MEM_RD held 4 cycles, MEM_WB mem_to_reg=01, count +1.
//  beq op4 zero_i=1 -> BRANCH pc_write=1 pc_src=01; bne op5 zero_i=1 -> pc_write=0; ble neg=0,zero=1 -> taken.
//  jal (op3) -> JAL: pc_write=1,pc_src=10,reg_write=1,reg_dst=10,mem_to_reg=11.
//  sw with mem_ready_i=0 held, MEM_TIMEOUT=15 -> bus_err_o pulse after 15 wait cycles, ->FETCH, count unchanged.
//  op 6'd63 -> illegal_o pulse in DECODE, ->FETCH; rst_i asserted in MEM_WB -> reg_write_o=0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle MIPS controller and its datapath.
// The controller (master) drives strobes and selects. The datapath (slave) returns opcode, ALU flags and memory ready.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic [5:0]       instr_op_i;
  logic             zero_i;
  logic             neg_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             ir_write_o;
  logic             i_or_d_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             reg_write_o;
  logic [1:0]       reg_dst_o;
  logic [1:0]       mem_to_reg_o;
  logic             alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [2:0]       alu_op_o;
  logic [1:0]       pc_src_o;
  logic [3:0]       state_o;
  logic             illegal_o;
  logic             bus_err_o;
  logic [CNT_W-1:0] instr_count_o;

  modport master (
    input  instr_op_i, zero_i, neg_i, mem_ready_i,
    output pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o,
           reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o,
           state_o, illegal_o, bus_err_o, instr_count_o
  );

  modport slave (
    output instr_op_i, zero_i, neg_i, mem_ready_i,
    input  pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o,
           reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o,
           state_o, illegal_o, bus_err_o, instr_count_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// resolves branches, aborts stalled memory accesses and counts retired instructions.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    JAL      = 4'd10,
    LUI_WB   = 4'd11
  } stateT;

  stateT            stateR;
  stateT            nextState;
  logic [7:0]       waitCntR;
  logic [CNT_W-1:0] instrCntR;

  logic       pcWrite, irWrite, iOrD, memRead, memWrite, regWrite, aluSrcA;
  logic       illegal, busErr, retire, waitStall, branchTaken, atLimit;
  logic [1:0] regDst, memToReg, aluSrcB, pcSrc;
  logic [2:0] aluOp;
  logic [5:0] op;

  assign op      = bus.instr_op_i;
  assign atLimit = (waitCntR == 8'(MEM_TIMEOUT));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateR <= FETCH;
    end else begin
      stateR <= nextState;
    end
  end

  // Memory wait-state counter; any state change or abort clears it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      waitCntR <= 8'd0;
    end else if (waitStall) begin
      waitCntR <= waitCntR + 8'd1;
    end else begin
      waitCntR <= 8'd0;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instrCntR <= '0;
    end else if (retire) begin
      instrCntR <= instrCntR + CNT_W'(1);
    end else begin
      instrCntR <= instrCntR;
    end
  end

  // Branch condition from the compare performed in BRANCH
  always_comb begin
    branchTaken = 1'b0;
    case (op)
      6'd4:    branchTaken = bus.zero_i;
      6'd5:    branchTaken = ~bus.zero_i;
      6'd6:    branchTaken = bus.neg_i;
      6'd7:    branchTaken = bus.neg_i | bus.zero_i;
      default: branchTaken = 1'b0;
    endcase
  end

  // Next-state and Moore output decode
  always_comb begin
    nextState = stateR;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    iOrD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    regDst    = 2'b00;
    memToReg  = 2'b00;
    aluSrcB   = 2'b00;
    pcSrc     = 2'b00;
    aluOp     = 3'b111;
    illegal   = 1'b0;
    busErr    = 1'b0;
    retire    = 1'b0;
    waitStall = 1'b0;
    case (stateR)
      FETCH: begin
        aluSrcB = 2'b01;
        aluOp   = 3'b011;
        if (bus.mem_ready_i) begin
          memRead   = 1'b1;
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          nextState = DECODE;
        end else if (atLimit) begin
          // PC was never advanced, so restarting FETCH refetches the same word
          busErr    = 1'b1;
          nextState = FETCH;
        end else begin
          memRead   = 1'b1;
          waitStall = 1'b1;
        end
      end
      DECODE: begin
        aluSrcB = 2'b11;
        aluOp   = 3'b011;
        case (op)
          6'd0, 6'd8, 6'd13:     nextState = EXEC;
          6'd2:                  nextState = JUMP;
          6'd3:                  nextState = JAL;
          6'd4, 6'd5, 6'd6, 6'd7: nextState = BRANCH;
          6'd15:                 nextState = LUI_WB;
          6'd35, 6'd43:          nextState = MEM_ADDR;
          default: begin
            illegal   = 1'b1;
            nextState = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        aluOp   = 3'b011;
        if (op == 6'd35) begin
          nextState = MEM_RD;
        end else begin
          nextState = MEM_WR;
        end
      end
      MEM_RD: begin
        iOrD = 1'b1;
        if (bus.mem_ready_i) begin
          memRead   = 1'b1;
          nextState = MEM_WB;
        end else if (atLimit) begin
          busErr    = 1'b1;
          nextState = FETCH;
        end else begin
          memRead   = 1'b1;
          waitStall = 1'b1;
        end
      end
      MEM_WB: begin
        regWrite  = 1'b1;
        memToReg  = 2'b01;
        retire    = 1'b1;
        nextState = FETCH;
      end
      MEM_WR: begin
        iOrD = 1'b1;
        if (bus.mem_ready_i) begin
          memWrite  = 1'b1;
          retire    = 1'b1;
          nextState = FETCH;
        end else if (atLimit) begin
          busErr    = 1'b1;
          nextState = FETCH;
        end else begin
          memWrite  = 1'b1;
          waitStall = 1'b1;
        end
      end
      EXEC: begin
        aluSrcA   = 1'b1;
        nextState = ALU_WB;
        case (op)
          6'd0: begin
            aluSrcB = 2'b00;
            aluOp   = 3'b000;
          end
          6'd8: begin
            aluSrcB = 2'b10;
            aluOp   = 3'b011;
          end
          6'd13: begin
            aluSrcB = 2'b10;
            aluOp   = 3'b101;
          end
          default: begin
            aluSrcB = 2'b00;
            aluOp   = 3'b111;
          end
        endcase
      end
      ALU_WB: begin
        regWrite  = 1'b1;
        regDst    = (op == 6'd0) ? 2'b01 : 2'b00;
        retire    = 1'b1;
        nextState = FETCH;
      end
      LUI_WB: begin
        aluOp     = 3'b100;
        regWrite  = 1'b1;
        memToReg  = 2'b10;
        retire    = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        aluSrcA   = 1'b1;
        aluOp     = (op == 6'd5) ? 3'b010 : 3'b001;
        pcWrite   = branchTaken;
        pcSrc     = 2'b01;
        retire    = 1'b1;
        nextState = FETCH;
      end
      JUMP: begin
        pcWrite   = 1'b1;
        pcSrc     = 2'b10;
        retire    = 1'b1;
        nextState = FETCH;
      end
      JAL: begin
        pcWrite   = 1'b1;
        pcSrc     = 2'b10;
        regWrite  = 1'b1;
        regDst    = 2'b10;
        memToReg  = 2'b11;
        retire    = 1'b1;
        nextState = FETCH;
      end
      default: begin
        nextState = FETCH;
      end
    endcase
  end

  // Reset also masks the decode so FETCH's read request is not issued while held in reset
  assign bus.pc_write_o    = pcWrite  & ~rst_i;
  assign bus.ir_write_o    = irWrite  & ~rst_i;
  assign bus.mem_read_o    = memRead  & ~rst_i;
  assign bus.mem_write_o   = memWrite & ~rst_i;
  assign bus.reg_write_o   = regWrite & ~rst_i;
  assign bus.illegal_o     = illegal  & ~rst_i;
  assign bus.bus_err_o     = busErr   & ~rst_i;
  assign bus.i_or_d_o      = iOrD     & ~rst_i;
  assign bus.alu_src_a_o   = aluSrcA  & ~rst_i;
  assign bus.reg_dst_o     = rst_i ? 2'b00  : regDst;
  assign bus.mem_to_reg_o  = rst_i ? 2'b00  : memToReg;
  assign bus.alu_src_b_o   = rst_i ? 2'b00  : aluSrcB;
  assign bus.alu_op_o      = rst_i ? 3'b000 : aluOp;
  assign bus.pc_src_o      = rst_i ? 2'b00  : pcSrc;
  assign bus.state_o       = rst_i ? 4'd0   : stateR;
  assign bus.instr_count_o = instrCntR;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction classes, wait states, timeout,
// illegal opcode and mid-instruction reset against hand-computed expectations.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, let combinational outputs settle
  task automatic step(input logic [5:0] op, input logic rdy, input logic z, input logic n);
    @(negedge clk);
    bus.instr_op_i  = op;
    bus.mem_ready_i = rdy;
    bus.zero_i      = z;
    bus.neg_i       = n;
    #1;
  endtask

  initial begin
    bus.instr_op_i  = 6'd0;
    bus.mem_ready_i = 1'b0;
    bus.zero_i      = 1'b0;
    bus.neg_i       = 1'b0;

    // Held in reset: everything quiet even though state is FETCH
    step(6'd0, 1'b1, 1'b0, 1'b0);
    step(6'd0, 1'b1, 1'b0, 1'b0);
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_mem_read", 32'(bus.mem_read_o), 32'd0);
    check("rst_ir_write", 32'(bus.ir_write_o), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op_o), 32'd0);
    check("rst_count", bus.instr_count_o, 32'd0);

    // add: 0,1,6,7
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("add_fetch_state", 32'(bus.state_o), 32'd0);
    check("add_fetch_read", 32'(bus.mem_read_o), 32'd1);
    check("add_fetch_irw", 32'(bus.ir_write_o), 32'd1);
    check("add_fetch_pcw", 32'(bus.pc_write_o), 32'd1);
    check("add_fetch_srcb", 32'(bus.alu_src_b_o), 32'd1);
    check("add_fetch_aluop", 32'(bus.alu_op_o), 32'd3);
    step(6'd0, 1'b1, 1'b0, 1'b0);
    check("add_decode_state", 32'(bus.state_o), 32'd1);
    check("add_decode_srcb", 32'(bus.alu_src_b_o), 32'd3);
    step(6'd0, 1'b1, 1'b0, 1'b0);
    check("add_exec_state", 32'(bus.state_o), 32'd6);
    check("add_exec_srca", 32'(bus.alu_src_a_o), 32'd1);
    check("add_exec_aluop", 32'(bus.alu_op_o), 32'd0);
    step(6'd0, 1'b1, 1'b0, 1'b0);
    check("add_wb_state", 32'(bus.state_o), 32'd7);
    check("add_wb_regw", 32'(bus.reg_write_o), 32'd1);
    check("add_wb_regdst", 32'(bus.reg_dst_o), 32'd1);
    check("add_wb_count_before", bus.instr_count_o, 32'd0);
    step(6'd35, 1'b1, 1'b0, 1'b0);
    check("add_count_after", bus.instr_count_o, 32'd1);

    // lw with three wait cycles in MEM_RD
    check("lw_fetch_state", 32'(bus.state_o), 32'd0);
    step(6'd35, 1'b0, 1'b0, 1'b0);
    check("lw_decode_state", 32'(bus.state_o), 32'd1);
    step(6'd35, 1'b0, 1'b0, 1'b0);
    check("lw_addr_state", 32'(bus.state_o), 32'd2);
    check("lw_addr_srcb", 32'(bus.alu_src_b_o), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(6'd35, 1'b0, 1'b0, 1'b0);
      check("lw_rd_wait_state", 32'(bus.state_o), 32'd3);
      check("lw_rd_wait_iord", 32'(bus.i_or_d_o), 32'd1);
      check("lw_rd_wait_read", 32'(bus.mem_read_o), 32'd1);
    end
    step(6'd35, 1'b1, 1'b0, 1'b0);
    check("lw_rd_ready_state", 32'(bus.state_o), 32'd3);
    step(6'd35, 1'b0, 1'b0, 1'b0);
    check("lw_wb_state", 32'(bus.state_o), 32'd4);
    check("lw_wb_mem2reg", 32'(bus.mem_to_reg_o), 32'd1);
    check("lw_wb_regw", 32'(bus.reg_write_o), 32'd1);
    check("lw_wb_regdst", 32'(bus.reg_dst_o), 32'd0);
    step(6'd4, 1'b1, 1'b0, 1'b0);
    check("lw_count", bus.instr_count_o, 32'd2);

    // beq taken
    step(6'd4, 1'b1, 1'b0, 1'b0);
    step(6'd4, 1'b1, 1'b1, 1'b0);
    check("beq_state", 32'(bus.state_o), 32'd8);
    check("beq_pcw", 32'(bus.pc_write_o), 32'd1);
    check("beq_pcsrc", 32'(bus.pc_src_o), 32'd1);
    check("beq_aluop", 32'(bus.alu_op_o), 32'd1);

    // bne not taken with zero set
    step(6'd5, 1'b1, 1'b0, 1'b0);
    check("beq_count", bus.instr_count_o, 32'd3);
    step(6'd5, 1'b1, 1'b0, 1'b0);
    step(6'd5, 1'b1, 1'b1, 1'b0);
    check("bne_pcw", 32'(bus.pc_write_o), 32'd0);
    check("bne_aluop", 32'(bus.alu_op_o), 32'd2);

    // ble taken on zero, blt not taken on zero
    step(6'd7, 1'b1, 1'b0, 1'b0);
    step(6'd7, 1'b1, 1'b0, 1'b0);
    step(6'd7, 1'b1, 1'b1, 1'b0);
    check("ble_pcw", 32'(bus.pc_write_o), 32'd1);
    step(6'd6, 1'b1, 1'b0, 1'b0);
    step(6'd6, 1'b1, 1'b0, 1'b0);
    step(6'd6, 1'b1, 1'b1, 1'b0);
    check("blt_pcw", 32'(bus.pc_write_o), 32'd0);

    // jal
    step(6'd3, 1'b1, 1'b0, 1'b0);
    check("branches_count", bus.instr_count_o, 32'd6);
    step(6'd3, 1'b1, 1'b0, 1'b0);
    step(6'd3, 1'b1, 1'b0, 1'b0);
    check("jal_state", 32'(bus.state_o), 32'd10);
    check("jal_pcw", 32'(bus.pc_write_o), 32'd1);
    check("jal_pcsrc", 32'(bus.pc_src_o), 32'd2);
    check("jal_regw", 32'(bus.reg_write_o), 32'd1);
    check("jal_regdst", 32'(bus.reg_dst_o), 32'd2);
    check("jal_mem2reg", 32'(bus.mem_to_reg_o), 32'd3);

    // sw that never completes: 15 wait cycles, then abort
    step(6'd43, 1'b1, 1'b0, 1'b0);
    check("jal_count", bus.instr_count_o, 32'd7);
    step(6'd43, 1'b0, 1'b0, 1'b0);
    step(6'd43, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(6'd43, 1'b0, 1'b0, 1'b0);
      check("sw_wait_state", 32'(bus.state_o), 32'd5);
      check("sw_wait_write", 32'(bus.mem_write_o), 32'd1);
      check("sw_wait_buserr", 32'(bus.bus_err_o), 32'd0);
    end
    step(6'd43, 1'b0, 1'b0, 1'b0);
    check("sw_to_state", 32'(bus.state_o), 32'd5);
    check("sw_to_buserr", 32'(bus.bus_err_o), 32'd1);
    check("sw_to_write", 32'(bus.mem_write_o), 32'd0);
    step(6'd63, 1'b1, 1'b0, 1'b0);
    check("sw_abort_state", 32'(bus.state_o), 32'd0);
    check("sw_abort_buserr", 32'(bus.bus_err_o), 32'd0);
    check("sw_abort_count", bus.instr_count_o, 32'd7);

    // Illegal opcode
    step(6'd63, 1'b1, 1'b0, 1'b0);
    check("ill_state", 32'(bus.state_o), 32'd1);
    check("ill_pulse", 32'(bus.illegal_o), 32'd1);
    step(6'd15, 1'b1, 1'b0, 1'b0);
    check("ill_back_fetch", 32'(bus.state_o), 32'd0);
    check("ill_pulse_end", 32'(bus.illegal_o), 32'd0);
    check("ill_count", bus.instr_count_o, 32'd7);

    // lui
    step(6'd15, 1'b1, 1'b0, 1'b0);
    step(6'd15, 1'b1, 1'b0, 1'b0);
    check("lui_state", 32'(bus.state_o), 32'd11);
    check("lui_aluop", 32'(bus.alu_op_o), 32'd4);
    check("lui_mem2reg", 32'(bus.mem_to_reg_o), 32'd2);
    check("lui_regw", 32'(bus.reg_write_o), 32'd1);

    // lw whose ready arrives exactly at the limit, then reset during MEM_WB
    step(6'd35, 1'b1, 1'b0, 1'b0);
    check("lui_count", bus.instr_count_o, 32'd8);
    step(6'd35, 1'b0, 1'b0, 1'b0);
    step(6'd35, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(6'd35, 1'b0, 1'b0, 1'b0);
    end
    step(6'd35, 1'b1, 1'b0, 1'b0);
    check("lim_state", 32'(bus.state_o), 32'd3);
    check("lim_buserr", 32'(bus.bus_err_o), 32'd0);
    check("lim_read", 32'(bus.mem_read_o), 32'd1);
    step(6'd35, 1'b0, 1'b0, 1'b0);
    check("lim_wb_state", 32'(bus.state_o), 32'd4);
    check("lim_wb_regw", 32'(bus.reg_write_o), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_regw", 32'(bus.reg_write_o), 32'd0);
    check("midrst_state", 32'(bus.state_o), 32'd0);
    check("midrst_count", bus.instr_count_o, 32'd0);
    step(6'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_state", 32'(bus.state_o), 32'd0);
    check("post_rst_read", 32'(bus.mem_read_o), 32'd1);
    step(6'd0, 1'b0, 1'b0, 1'b0);
    check("post_rst_count", bus.instr_count_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
